// File: rtl/gf_pkg.sv
// Shared GF(2^M) constants, state encoding and sizing helper for the RS datapath.
package gf_pkg;

  // Default field: GF(32) with x^5 + x^2 + 1
  localparam int unsigned GF_M    = 5;
  localparam int unsigned GF_POLY = 32'h25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gf_state_e;

  // Bit-position counter width for an M-bit multiplier operand
  function automatic int unsigned cnt_width(input int unsigned m);
    return $clog2(m);
  endfunction

endpackage

// File: rtl/gf_mul_serial_if.sv
// Operand/result handshake bundle for the serial GF multiplier.
interface gf_mul_serial_if import gf_pkg::*; #(
  parameter int unsigned M = GF_M
);

  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] in_a;
  logic [M-1:0] in_b;
  logic         in_acc;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] out_z;

  // Producer of operands / consumer of results
  modport master (
    output in_valid, in_a, in_b, in_acc, out_ready,
    input  in_ready, out_valid, out_z
  );

  // The multiplier itself
  modport slave (
    input  in_valid, in_a, in_b, in_acc, out_ready,
    output in_ready, out_valid, out_z
  );

endinterface

// File: rtl/gf_xtime.sv
// Combinational multiply-by-alpha in GF(2^M): shift left, reduce by POLY on carry-out.
module gf_xtime import gf_pkg::*; #(
  parameter int unsigned M    = GF_M,
  parameter int unsigned POLY = GF_POLY
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] y
);

  localparam logic [M-1:0] RED = M'(POLY);

  // Shifted-out x^M term folds back as the low part of the polynomial
  always_comb begin
    y = {a[M-2:0], 1'b0} ^ (a[M-1] ? RED : '0);
  end

endmodule

// File: rtl/gf_mul_serial.sv
// Bit-serial GF(2^M) multiplier/accumulator, MSB-first Horner, M cycles per product.
// Optional build macro GF_MUL_BYPASS_EN: trivial operands (a==0, b==0, b==1)
// skip the serial loop and complete on the accept edge.
module gf_mul_serial import gf_pkg::*; #(
  parameter int unsigned M    = GF_M,
  parameter int unsigned POLY = GF_POLY
) (
  input  logic           clk,
  input  logic           rst_n,
  gf_mul_serial_if.slave bus,
  input  logic           acc_clr,
  output logic           busy,
  output logic [M-1:0]   acc
);

  localparam int unsigned CNT_W = cnt_width(M);

  if (((POLY >> M) & 32'd1) == 32'd0) begin : g_poly_chk
    $error("gf_mul_serial: POLY must include the x^M term");
  end
  if (M < 3 || M > 16) begin : g_m_chk
    $error("gf_mul_serial: M must be in 3..16");
  end

  gf_state_e        state_q, state_d;
  logic [M-1:0]     a_q, a_d;
  logic [M-1:0]     b_q, b_d;
  logic             mode_q, mode_d;
  logic [M-1:0]     p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [M-1:0]     z_q, z_d;
  logic [M-1:0]     acc_q, acc_d;
  logic             rdy;
  logic [M-1:0]     p_xt;
  logic [M-1:0]     p_step;
  logic [M-1:0]     p_res;

  gf_xtime #(.M(M), .POLY(POLY)) u_xtime (
    .a (p_q),
    .y (p_xt)
  );

  // One Horner step and the value it would publish on the final step
  always_comb begin
    p_step = p_xt ^ (b_q[cnt_q] ? a_q : '0);
    p_res  = mode_q ? (acc_q ^ p_step) : p_step;
  end

`ifdef GF_MUL_BYPASS_EN
  logic         byp;
  logic [M-1:0] byp_res;

  // Trivial products: zero operand gives 0, b==1 gives a
  always_comb begin
    byp     = (bus.in_a == '0) || (bus.in_b == '0) || (bus.in_b == M'(1));
    byp_res = ((bus.in_b == M'(1)) ? bus.in_a : '0) ^ (bus.in_acc ? acc_q : '0);
  end
`endif

  // Next-state, handshake and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    acc_d   = acc_q;
    rdy     = 1'b0;

    case (state_q)
      IDLE: rdy = 1'b1;
      RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          z_d     = p_res;
          if (mode_q) acc_d = p_res;
        end
      end
      DONE: begin
        rdy = bus.out_ready;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accept from IDLE, or hand over straight from DONE when the result is taken
    if (bus.in_valid && rdy) begin
      a_d     = bus.in_a;
      b_d     = bus.in_b;
      mode_d  = bus.in_acc;
      p_d     = '0;
      cnt_d   = CNT_W'(M - 1);
      state_d = RUN;
`ifdef GF_MUL_BYPASS_EN
      if (byp) begin
        state_d = DONE;
        z_d     = byp_res;
        if (bus.in_acc) acc_d = byp_res;
      end
`endif
    end

    // Clear has priority over any accumulate write-back
    if (acc_clr) acc_d = '0;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      p_q     <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_z     = z_q;
  assign busy          = (state_q == RUN);
  assign acc           = acc_q;

endmodule

// File: tb/tb_gf_mul_serial.sv
// Directed + random bench for gf_mul_serial on GF(32)/0x25 and GF(256)/0x11D.
module tb_gf_mul_serial;

  typedef struct {
    int unsigned z;
    int unsigned acc;
    int unsigned lat;
    int unsigned cyc_acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr5, clr8;
  logic        busy5, busy8;
  logic [4:0]  acc5;
  logic [7:0]  acc8;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  int unsigned acc_model = 0;
  exp_t        q5[$];
  int unsigned q8[$];

  gf_mul_serial_if #(.M(5)) bus5 ();
  gf_mul_serial_if #(.M(8)) bus8 ();

  gf_mul_serial #(.M(5), .POLY(32'h25)) u5 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus5),
    .acc_clr (clr5),
    .busy    (busy5),
    .acc     (acc5)
  );

  gf_mul_serial #(.M(8), .POLY(32'h11D)) u8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus8),
    .acc_clr (clr8),
    .busy    (busy8),
    .acc     (acc8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: LSB-first shift-and-add with reduction
  function automatic int unsigned gfmul(input int unsigned a, input int unsigned b,
                                        input int unsigned m, input int unsigned poly);
    int unsigned r = 0;
    int unsigned x = a;
    for (int i = 0; i < 32; i++) begin
      if (((b >> i) & 1) != 0) r = r ^ x;
      x = x << 1;
      if (((x >> m) & 1) != 0) x = x ^ poly;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send5(input int unsigned a, input int unsigned b, input bit am);
    exp_t e;
    bit   byp;
    int   guard = 0;
    byp = 1'b0;
`ifdef GF_MUL_BYPASS_EN
    byp = (a == 0) || (b == 0) || (b == 1);
`endif
    while (bus5.in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_wait", 32'(bus5.in_ready), 32'd1);
    bus5.in_valid = 1'b1;
    bus5.in_a     = 5'(a);
    bus5.in_b     = 5'(b);
    bus5.in_acc   = am;
    @(posedge clk); #1;
    bus5.in_valid = 1'b0;
    e.z = gfmul(a, b, 5, 32'h25) ^ (am ? acc_model : 0);
    if (am) acc_model = e.z;
    e.acc     = acc_model;
    e.lat     = byp ? 0 : 5;
    e.cyc_acc = cyc;
    q5.push_back(e);
    check("accept_busy", 32'(busy5), byp ? 32'd0 : 32'd1);
    check("accept_valid", 32'(bus5.out_valid), byp ? 32'd1 : 32'd0);
  endtask

  task automatic recv5(input string tag);
    exp_t e;
    int   guard = 0;
    while (bus5.out_valid !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_valid"}, 32'(bus5.out_valid), 32'd1);
    check({tag, "_sb"}, 32'(q5.size()), 32'd1);
    if (q5.size() > 0) begin
      e = q5.pop_front();
      check({tag, "_lat"}, cyc - e.cyc_acc, e.lat);
      check({tag, "_z"}, 32'(bus5.out_z), e.z);
      check({tag, "_acc"}, 32'(acc5), e.acc);
    end
  endtask

  task automatic op8(input int unsigned a, input int unsigned b, input int unsigned zexp);
    int guard = 0;
    bus8.in_valid = 1'b1;
    bus8.in_a     = 8'(a);
    bus8.in_b     = 8'(b);
    bus8.in_acc   = 1'b0;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    q8.push_back(zexp);
    while (bus8.out_valid !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("m8_valid", 32'(bus8.out_valid), 32'd1);
    if (q8.size() > 0) check("m8_z", 32'(bus8.out_z), q8.pop_front());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned hold_z;
    int unsigned ra, rb;

    rst_n = 1'b0;
    clr5 = 1'b0; clr8 = 1'b0;
    bus5.in_valid = 1'b0; bus5.in_a = '0; bus5.in_b = '0; bus5.in_acc = 1'b0; bus5.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_acc = 1'b0; bus8.out_ready = 1'b1;

    // Reset values
    #22;
    check("rst_in_ready", 32'(bus5.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus5.out_valid), 32'd0);
    check("rst_out_z", 32'(bus5.out_z), 32'd0);
    check("rst_busy", 32'(busy5), 32'd0);
    check("rst_acc", 32'(acc5), 32'd0);
    check("rst8_busy", 32'(busy8), 32'd0);
    check("rst8_acc", 32'(acc8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain products
    send5(2, 16, 0); recv5("p_2x16");
    send5(2, 18, 0); recv5("p_2x18");
    send5(3, 3, 0);  recv5("p_3x3");

    // Accumulate sequence
    clr5 = 1'b1; @(posedge clk); #1; clr5 = 1'b0;
    acc_model = 0;
    check("clr_acc", 32'(acc5), 32'd0);
    send5(2, 16, 1); recv5("a_2x16");
    send5(3, 3, 1);  recv5("a_3x3");
    send5(7, 1, 0);  recv5("a_plain7");
    send5(5, 6, 1);  recv5("a_5x6");
    clr5 = 1'b1; @(posedge clk); #1; clr5 = 1'b0;
    acc_model = 0;
    check("clr2_acc", 32'(acc5), 32'd0);

    // Backpressure: result held while out_ready is low
    send5(9, 7, 0);
    bus5.out_ready = 1'b0;
    recv5("bp");
    hold_z = gfmul(9, 7, 5, 32'h25);
    bus5.in_valid = 1'b1; bus5.in_a = 5'd6; bus5.in_b = 5'd11; bus5.in_acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(bus5.out_valid), 32'd1);
      check("bp_z", 32'(bus5.out_z), hold_z);
      check("bp_in_ready", 32'(bus5.in_ready), 32'd0);
    end
    bus5.out_ready = 1'b1;
    send5(6, 11, 0); recv5("bp_next");

    // Reset in the middle of a run
    send5(5, 6, 1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(bus5.out_valid), 32'd0);
    check("mrst_busy", 32'(busy5), 32'd0);
    check("mrst_in_ready", 32'(bus5.in_ready), 32'd1);
    check("mrst_out_z", 32'(bus5.out_z), 32'd0);
    check("mrst_acc", 32'(acc5), 32'd0);
    q5.delete();
    acc_model = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send5(4, 8, 0); recv5("post_rst");

    // Trivial operands (skip the loop only in the bypass build)
    send5(0, 9, 0);  recv5("t_0x9");
    send5(13, 1, 0); recv5("t_13x1");
    send5(13, 1, 1); recv5("t_13x1_acc");
    send5(2, 16, 0); recv5("t_2x16");

    // GF(256) with 0x11D
    op8(8'h80, 8'h02, 32'h1D);
    for (int i = 0; i < 2000; i++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      op8(ra, rb, gfmul(ra, rb, 8, 32'h11D));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
